ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, consuming the decoded operation bundle produced by the decode stage (aluop, alusel, reg1, reg2, wd, wreg). It computes logic, shift, compare, add/sub and move results, owns the HI/LO register pair, and runs MULT/MULTU on a 32-cycle iterative shift-add multiplier. While a multiply is in flight it stalls the front of the pipeline through a valid/ready handshake. Its registered outputs feed the memory stage.

---
 rtl/ex_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_ex_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU/shift/compare/move datapath, HI/LO ownership, and a
// 32-step iterative shift-add multiplier that holds off the pipeline front.
package ex_pkg;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;
  localparam logic [2:0] EXE_RES_MUL   = 3'b101;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;

  typedef enum logic {IDLE, MUL} mul_state_e;
endpackage

module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic        valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  mul_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        valid_q, valid_d, wreg_q, wreg_d;
  logic [4:0]  wd_q, wd_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] res, sum, diff, abs1, abs2;
  logic        res_we, mul_start, mul_signed, mthi, mtlo;
  logic [63:0] acc_n;
  logic        accept;

  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i && ready_o;
  assign sum     = reg1_i + reg2_i;
  assign diff    = reg1_i - reg2_i;

  // Result datapath for single-cycle ops; anything unrecognised behaves as NOP.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    res        = 32'h0;
    res_we     = 1'b0;
    mul_start  = 1'b0;
    mul_signed = 1'b0;
    mthi       = 1'b0;
    mtlo       = 1'b0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        res_we = wreg_i;
        case (aluop_i)
          EXE_AND_OP: res = reg1_i & reg2_i;
          EXE_OR_OP:  res = reg1_i | reg2_i;
          EXE_XOR_OP: res = reg1_i ^ reg2_i;
          EXE_NOR_OP: res = ~(reg1_i | reg2_i);
          default:    res_we = 1'b0;
        endcase
      end
      EXE_RES_SHIFT: begin
        res_we = wreg_i;
        case (aluop_i)
          EXE_SLL_OP: res = reg2_i << reg1_i[4:0];
          EXE_SRL_OP: res = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP: res = $signed(reg2_i) >>> reg1_i[4:0];
          default:    res_we = 1'b0;
        endcase
      end
      EXE_RES_ARITH: begin
        res_we = wreg_i;
        case (aluop_i)
          EXE_SLT_OP:  res = {31'h0, $signed(reg1_i) < $signed(reg2_i)};
          EXE_SLTU_OP: res = {31'h0, reg1_i < reg2_i};
          EXE_ADDU_OP: res = sum;
          EXE_SUBU_OP: res = diff;
          EXE_ADD_OP: begin
            res = sum;
            if (reg1_i[31] == reg2_i[31] && sum[31] != reg1_i[31]) res_we = 1'b0;
          end
          EXE_SUB_OP: begin
            res = diff;
            if (reg1_i[31] != reg2_i[31] && diff[31] != reg1_i[31]) res_we = 1'b0;
          end
          default: res_we = 1'b0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MOVZ_OP: begin res = reg1_i; res_we = wreg_i && (reg2_i == 32'h0); end
          EXE_MOVN_OP: begin res = reg1_i; res_we = wreg_i && (reg2_i != 32'h0); end
          EXE_MFHI_OP: begin res = hi_q;   res_we = wreg_i; end
          EXE_MFLO_OP: begin res = lo_q;   res_we = wreg_i; end
          EXE_MTHI_OP: mthi = 1'b1;
          EXE_MTLO_OP: mtlo = 1'b1;
          default: ;
        endcase
      end
      EXE_RES_MUL: begin
        mul_start  = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
        mul_signed = (aluop_i == EXE_MULT_OP);
      end
      default: ;
    endcase
  end

  // 0x80000000 negates to itself, which is its correct unsigned magnitude.
  assign abs1 = (mul_signed && reg1_i[31]) ? -reg1_i : reg1_i;
  assign abs2 = (mul_signed && reg2_i[31]) ? -reg2_i : reg2_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    valid_d  = 1'b0;
    wreg_d   = 1'b0;
    wd_d     = wd_q;
    wdata_d  = wdata_q;
    acc_n    = acc_q + (mplier_q[0] ? mcand_q : 64'h0);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mul_start) begin
            state_d  = MUL;
            cnt_d    = 5'd0;
            mcand_d  = {32'h0, abs1};
            mplier_d = abs2;
            acc_d    = 64'h0;
            neg_d    = mul_signed && (reg1_i[31] ^ reg2_i[31]);
          end else begin
            valid_d = 1'b1;
            wd_d    = wd_i;
            wreg_d  = res_we;
            wdata_d = res;
            if (mthi) hi_d = reg1_i;
            if (mtlo) lo_d = reg1_i;
          end
        end
      end
      MUL: begin
        acc_d    = acc_n;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          {hi_d, lo_d} = neg_q ? -acc_n : acc_n;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= 64'h0;
      mplier_q <= 32'h0;
      acc_q    <= 64'h0;
      neg_q    <= 1'b0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      wd_q     <= 5'd0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
      wreg_q   <= wreg_d;
      wd_q     <= wd_d;
      wdata_q  <= wdata_d;
    end
  end

  assign valid_o = valid_q;
  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboarded bench for ex_stage: single-cycle ops are queued at issue and
// checked as results emerge; multiply timing and HI/LO are checked directly.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  aluop_i = 8'h0;
  logic [2:0]  alusel_i = 3'h0;
  logic [31:0] reg1_i = 32'h0, reg2_i = 32'h0;
  logic [4:0]  wd_i = 5'h0;
  logic        wreg_i = 1'b0;
  logic        valid_o, wreg_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  ex_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .valid_o(valid_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Every valid result must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(valid_o), 64'd0);
      end else begin
        sb_e = sb.pop_front();
        check("wd", 64'(wd_o), 64'(sb_e.wd));
        check("wreg", 64'(wreg_o), 64'(sb_e.wreg));
        if (sb_e.chk_data) check("wdata", 64'(wdata_o), 64'(sb_e.wdata));
      end
    end
  end

  task automatic issue(input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] wd, input logic we);
    @(negedge clk);
    valid_i  = 1'b1;
    alusel_i = sel;
    aluop_i  = op;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = wd;
    wreg_i   = we;
  endtask

  task automatic expect_res(input logic [4:0] wd, input logic we,
                            input logic [31:0] data, input logic chk);
    exp_t e;
    e.wd = wd; e.wreg = we; e.wdata = data; e.chk_data = chk;
    sb.push_back(e);
  endtask

  task automatic alu(input logic [2:0] sel, input logic [7:0] op,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic [4:0] wd, input logic we,
                     input logic exp_we, input logic [31:0] exp_data);
    issue(sel, op, r1, r2, wd, we);
    expect_res(wd, exp_we, exp_data, 1'b1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Issues a multiply and returns how many sampled cycles ready_o stayed low.
  task automatic run_mul(input logic [7:0] op, input logic [31:0] r1,
                         input logic [31:0] r2, output int low_cycles);
    issue(EXE_RES_MUL, op, r1, r2, 5'd9, 1'b1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    low_cycles = 0;
    while (!ready_o && low_cycles < 40) begin
      low_cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  int lows;
  logic [31:0] ra, rb;
  logic [4:0]  rw;
  logic        rwe;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_wd_wdata", {27'h0, wd_o, wdata_o}, 64'd0);
    idle(2);
    check("idle_valid", 64'(valid_o), 64'd0);

    // Back-to-back single-cycle ops.
    alu(EXE_RES_LOGIC, EXE_OR_OP,   32'h0000_1234, 32'hFFFF_0000, 5'd5, 1'b1, 1'b1, 32'hFFFF_1234);
    alu(EXE_RES_LOGIC, EXE_XOR_OP,  32'h0,         32'h1234_0000, 5'd6, 1'b1, 1'b1, 32'h1234_0000);
    alu(EXE_RES_LOGIC, EXE_NOR_OP,  32'h0F0F_0000, 32'h0000_00FF, 5'd7, 1'b1, 1'b1, 32'hF0F0_FF00);
    alu(EXE_RES_LOGIC, EXE_AND_OP,  32'hFFFF_FFFF, 32'h00AA_5500, 5'd8, 1'b0, 1'b0, 32'h00AA_5500);
    alu(EXE_RES_SHIFT, EXE_SRA_OP,  32'd4,         32'h8000_0000, 5'd1, 1'b1, 1'b1, 32'hF800_0000);
    alu(EXE_RES_SHIFT, EXE_SRL_OP,  32'd4,         32'h8000_0000, 5'd2, 1'b1, 1'b1, 32'h0800_0000);
    alu(EXE_RES_SHIFT, EXE_SLL_OP,  32'hFFFF_FFE4, 32'h0000_0001, 5'd3, 1'b1, 1'b1, 32'h0000_0010);
    alu(EXE_RES_ARITH, EXE_SLTU_OP, 32'd1,         32'hFFFF_FFFF, 5'd4, 1'b1, 1'b1, 32'd1);
    alu(EXE_RES_ARITH, EXE_SLT_OP,  32'd1,         32'hFFFF_FFFF, 5'd4, 1'b1, 1'b1, 32'd0);
    issue(EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFF_FFFF, 32'd1, 5'd10, 1'b1);
    expect_res(5'd10, 1'b0, 32'h0, 1'b0);
    alu(EXE_RES_ARITH, EXE_ADDU_OP, 32'h7FFF_FFFF, 32'd1,         5'd10, 1'b1, 1'b1, 32'h8000_0000);
    issue(EXE_RES_ARITH, EXE_SUB_OP, 32'h8000_0000, 32'd1, 5'd11, 1'b1);
    expect_res(5'd11, 1'b0, 32'h0, 1'b0);
    alu(EXE_RES_ARITH, EXE_SUB_OP,  32'd5,         32'd7,         5'd12, 1'b1, 1'b1, 32'hFFFF_FFFE);
    alu(EXE_RES_ARITH, EXE_SUBU_OP, 32'h8000_0000, 32'd1,         5'd13, 1'b1, 1'b1, 32'h7FFF_FFFF);
    issue(EXE_RES_MOVE, EXE_MOVZ_OP, 32'h1111_1111, 32'd1, 5'd14, 1'b1);
    expect_res(5'd14, 1'b0, 32'h0, 1'b0);
    alu(EXE_RES_MOVE,  EXE_MOVZ_OP, 32'h2222_2222, 32'd0,         5'd15, 1'b1, 1'b1, 32'h2222_2222);
    alu(EXE_RES_MOVE,  EXE_MOVN_OP, 32'h3333_3333, 32'd9,         5'd16, 1'b1, 1'b1, 32'h3333_3333);
    alu(EXE_RES_NOP,   EXE_NOP_OP,  32'hAAAA_AAAA, 32'h5555_5555, 5'd17, 1'b1, 1'b0, 32'h0);
    alu(EXE_RES_LOGIC, 8'hEE,       32'hAAAA_AAAA, 32'h5555_5555, 5'd18, 1'b1, 1'b0, 32'h0);
    // MTHI then MFHI on the very next edge must see the new value.
    alu(EXE_RES_MOVE,  EXE_MTHI_OP, 32'hDEAD_BEEF, 32'h0,         5'd19, 1'b1, 1'b0, 32'h0);
    alu(EXE_RES_MOVE,  EXE_MFHI_OP, 32'h0,         32'h0,         5'd20, 1'b1, 1'b1, 32'hDEAD_BEEF);
    alu(EXE_RES_MOVE,  EXE_MTLO_OP, 32'h0BAD_F00D, 32'h0,         5'd21, 1'b1, 1'b0, 32'h0);
    alu(EXE_RES_MOVE,  EXE_MFLO_OP, 32'h0,         32'h0,         5'd22, 1'b1, 1'b1, 32'h0BAD_F00D);

    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rw  = 5'($urandom_range(31));
      rwe = 1'($urandom_range(1));
      if (i[0]) alu(EXE_RES_ARITH, EXE_ADDU_OP, ra, rb, rw, rwe, rwe, ra + rb);
      else      alu(EXE_RES_LOGIC, EXE_XOR_OP,  ra, rb, rw, rwe, rwe, ra ^ rb);
    end
    idle(2);
    check("sb_drained_alu", 64'(sb.size()), 64'd0);

    run_mul(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, lows);
    check("mult_ready_low", 64'(lows), 64'd32);
    check("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    alu(EXE_RES_MOVE, EXE_MFLO_OP, 32'h0, 32'h0, 5'd23, 1'b1, 1'b1, 32'hFFFF_FFFA);
    alu(EXE_RES_MOVE, EXE_MFHI_OP, 32'h0, 32'h0, 5'd24, 1'b1, 1'b1, 32'hFFFF_FFFF);
    idle(1);

    run_mul(EXE_MULT_OP, 32'h8000_0000, 32'h8000_0000, lows);
    check("mult_min_hilo", {hi_o, lo_o}, 64'h4000_0000_0000_0000);
    run_mul(EXE_MULT_OP, 32'd7, 32'hFFFF_FFFB, lows);
    check("mult_neg_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFDD);
    run_mul(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lows);
    check("multu_ready_low", 64'(lows), 64'd32);
    check("multu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

    // Reset in the middle of a multiply must abort it without a late write.
    issue(EXE_RES_MUL, EXE_MULT_OP, 32'd7, 32'd9, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("mul_busy", 64'(ready_o), 64'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", 64'(ready_o), 64'd1);
    check("abort_hilo", {hi_o, lo_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_late_write", {hi_o, lo_o}, 64'd0);

    idle(2);
    check("sb_drained_end", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
